prio_enco_nor_struct: RTL and testbench
=======================================

Name:
prio_enco_nor_struct

Overview:
- 8-to-3 priority encoder for the elevator floor-selection path.
- d carries one request bit per floor; q gives the index of the highest requested floor.
- Encoding logic is built only from NOR gates, with a registered output stage on one clock.
- Sits between the floor-request collection logic and the elevator destination controller.

Parameters:
- WIDTH, 8, number of floor-request inputs. Only 8 is supported; the NOR network is fixed for 8 inputs.
- DEPTH, 3, encoded output width, equal to clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- d  input  WIDTH  floor request vector; bit i high means floor i is requested; d[7] has highest priority.
- q  output  DEPTH  registered index of the highest-priority active request.
- valid  output  1  registered; high when at least one bit of d was set in the sampled cycle.

Behaviour:
- Reset: at a rising edge with rst_n=0, q<=3'b000 and valid<=0. Reset overrides d.
- Normal operation: at each rising edge with rst_n=1, q<=enc(d) and valid<=|d.
- Latency: exactly 1 clock from d to q/valid. No combinational path from d to the outputs.
- enc(d) is the highest index i with d[i]=1. Lower-priority bits are don't-care once a higher bit is set.
- enc(d) is built from 2-, 3- and 4-input NOR gates only. Inverters are NOR gates with both inputs tied together.
- Required equations, where ~ denotes NOR-derived inversion:
  - q2 = d7|d6|d5|d4
  - q1 = d7|d6|(~d5&~d4&d3)|(~d5&~d4&d2)
  - q0 = d7|(~d6&d5)|(~d6&~d4&d3)|(~d6&~d4&~d2&d1)
- Boundary cases:
  - d=0: q=000 and valid=0.
  - d=8'b00000001: q=000 and valid=1. Only valid distinguishes this from no request.
- Each cycle is evaluated independently. There is no request latching or clearing.
- rst_n deasserted mid-stream: the first rising edge with rst_n=1 loads enc(d) from the current d.
- d may change every cycle. The value sampled at the rising edge is the one that is encoded.

Test Plan:
- Reset and zero: rst_n=0 for 2 edges, with d=8'hFF held throughout -> q=000, valid=0. Then release rst_n with d=8'h00 -> q=000, valid=0.
- One-hot sweep: d=1<<i for i=0..7, one per cycle -> q=i and valid=1, each one cycle after its input.
- Priority masking:
  - d=8'b10110101 -> q=111.
  - d=8'b00101100 -> q=101.
  - d=8'b00001010 -> q=011.
  - d=8'b01010000 -> q=110.
  - valid=1 in all four cases.
- Low floors: d=8'b00000110 -> q=010. d=8'b00000011 -> q=001. d=8'b00000001 -> q=000 with valid=1.
- Mid-stream reset: d=8'b10000000, then assert rst_n=0 for one edge -> q=000, valid=0. Release -> q=111 on the next edge.
- Random: 1000 random d values, checking each cycle that q equals the highest-set-bit index and valid equals |d, both with one-cycle latency.

Source files
------------

// File: rtl/prio_enco_nor_struct_if.sv
// Floor-request bus between the request collector and the priority encoder.
// The master drives the request vector; the slave returns the encoded floor index.
interface prio_enco_nor_struct_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    logic [WIDTH-1:0] d;
    logic [DEPTH-1:0] q;
    logic             valid;

    modport master (
        output d,
        input  q,
        input  valid
    );

    modport slave (
        input  d,
        output q,
        output valid
    );
endinterface

// File: rtl/prio_enco_nor_struct.sv
// 8-to-3 priority encoder for floor selection, built from a NOR-only network.
// The encoded index and request-present flag are registered once, with a synchronous active-low reset.
module prio_enco_nor_struct #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prio_enco_nor_struct_if.slave bus
);
    logic [WIDTH-1:0] d;
    logic [DEPTH-1:0] q_d, q_q;
    logic             valid_d, valid_q;

    assign d = bus.d;

    // Inverters are two-input NORs with both inputs tied together
    logic nd1, nd2, nd3, nd5;
    assign nd1 = ~(d[1] | d[1]);
    assign nd2 = ~(d[2] | d[2]);
    assign nd3 = ~(d[3] | d[3]);
    assign nd5 = ~(d[5] | d[5]);

    // q2 = d7|d6|d5|d4
    logic q2_n, q2;
    assign q2_n = ~(d[7] | d[6] | d[5] | d[4]);
    assign q2   = ~(q2_n | q2_n);

    // q1 = d7|d6|(~d5&~d4&d3)|(~d5&~d4&d2)
    logic q1_t3, q1_t2, q1_n, q1;
    assign q1_t3 = ~(d[5] | d[4] | nd3);
    assign q1_t2 = ~(d[5] | d[4] | nd2);
    assign q1_n  = ~(d[7] | d[6] | q1_t3 | q1_t2);
    assign q1    = ~(q1_n | q1_n);

    // q0 = d7|(~d6&d5)|(~d6&~d4&d3)|(~d6&~d4&~d2&d1)
    logic q0_t5, q0_t3, q0_t1, q0_n, q0;
    assign q0_t5 = ~(d[6] | nd5);
    assign q0_t3 = ~(d[6] | d[4] | nd3);
    assign q0_t1 = ~(d[6] | d[4] | d[2] | nd1);
    assign q0_n  = ~(d[7] | q0_t5 | q0_t3 | q0_t1);
    assign q0    = ~(q0_n | q0_n);

    // Request-present flag reuses the upper-half OR from q2
    logic lo_n, lo, none;
    assign lo_n = ~(d[3] | d[2] | d[1] | d[0]);
    assign lo   = ~(lo_n | lo_n);
    assign none = ~(q2 | lo);

    assign q_d     = {q2, q1, q0};
    assign valid_d = ~(none | none);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_prio_enco_nor_struct.sv
// Scoreboard bench for prio_enco_nor_struct: the driver queues expected results,
// a negedge monitor pops and compares them in the cycle each one becomes due.
module tb_prio_enco_nor_struct;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int         due;
        logic [7:0] d;
        logic [2:0] q;
        logic       v;
    } exp_t;

    exp_t sb[$];

    prio_enco_nor_struct_if #(.WIDTH(8), .DEPTH(3)) bus ();

    prio_enco_nor_struct dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] model_enc(input logic [7:0] dv);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++)
            if (dv[i]) r = 3'(i);
        return r;
    endfunction

    // Inputs set just after edge n are captured at edge n+1
    task automatic apply(input logic r, input logic [7:0] dv,
                         input logic [2:0] eq, input logic ev);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        bus.d = dv;
        e.due = cyc + 1;
        e.d   = dv;
        e.q   = eq;
        e.v   = ev;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.due != cyc) begin
                errors++;
                $display("FAIL sched cyc=%0d got_due=%0d", cyc, e.due);
            end
            checks++;
            if (bus.q !== e.q) begin
                errors++;
                $display("FAIL q cyc=%0d d=%b got %b exp %b", cyc, e.d, bus.q, e.q);
            end
            checks++;
            if (bus.valid !== e.v) begin
                errors++;
                $display("FAIL valid cyc=%0d d=%b got %b exp %b", cyc, e.d, bus.valid, e.v);
            end
        end
    end

    initial begin
        logic [7:0] rv;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.d  = 8'hFF;

        // Reset holds outputs at zero regardless of d, then all-zero request
        apply(1'b0, 8'hFF, 3'd0, 1'b0);
        apply(1'b0, 8'hFF, 3'd0, 1'b0);
        apply(1'b1, 8'h00, 3'd0, 1'b0);

        // One-hot sweep
        apply(1'b1, 8'b00000001, 3'd0, 1'b1);
        apply(1'b1, 8'b00000010, 3'd1, 1'b1);
        apply(1'b1, 8'b00000100, 3'd2, 1'b1);
        apply(1'b1, 8'b00001000, 3'd3, 1'b1);
        apply(1'b1, 8'b00010000, 3'd4, 1'b1);
        apply(1'b1, 8'b00100000, 3'd5, 1'b1);
        apply(1'b1, 8'b01000000, 3'd6, 1'b1);
        apply(1'b1, 8'b10000000, 3'd7, 1'b1);

        // Priority masking
        apply(1'b1, 8'b10110101, 3'b111, 1'b1);
        apply(1'b1, 8'b00101100, 3'b101, 1'b1);
        apply(1'b1, 8'b00001010, 3'b011, 1'b1);
        apply(1'b1, 8'b01010000, 3'b110, 1'b1);

        // Low floors
        apply(1'b1, 8'b00000110, 3'b010, 1'b1);
        apply(1'b1, 8'b00000011, 3'b001, 1'b1);
        apply(1'b1, 8'b00000001, 3'b000, 1'b1);
        apply(1'b1, 8'b00000000, 3'b000, 1'b0);

        // Mid-stream reset
        apply(1'b1, 8'b10000000, 3'b111, 1'b1);
        apply(1'b0, 8'b10000000, 3'b000, 1'b0);
        apply(1'b1, 8'b10000000, 3'b111, 1'b1);

        // Random
        for (int n = 0; n < 1000; n++) begin
            rv = 8'($urandom);
            apply(1'b1, rv, model_enc(rv), |rv);
        end

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d", sb.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
